// File: rtl/prefetch_ring_pkg.sv
// Shared types and helpers for the prefetch ring tracker.
// The typedefs describe the default LOG_DEPTH=3 / 64-bit address configuration.
package prefetch_ring_pkg;

    localparam int LOG_DEPTH_DEF  = 3;
    localparam int ADDR_WIDTH_DEF = 64;

    typedef logic [LOG_DEPTH_DEF-1:0] idx_t;
    typedef logic [LOG_DEPTH_DEF:0]   cnt_t;

    typedef struct packed {
        logic [ADDR_WIDTH_DEF-1:0] addr;
        logic                      done;
    } ring_entry_t;

    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned depth);
        return (idx + 1) % depth;
    endfunction

endpackage

// File: rtl/prefetch_ring_tracker_vectormask.sv
// Cyclic region mask: bit i is set when i lies in [headIdx, tailIdx) modulo the width.
// tailIdx < headIdx yields the wrapped (inverted) region; head == tail yields all zeros.
module vectorMask #(
    parameter int LOG_WIDTH = 3
) (
    input  logic [LOG_WIDTH-1:0]      headIdx,
    input  logic [LOG_WIDTH-1:0]      tailIdx,
    output logic [(1<<LOG_WIDTH)-1:0] mask
);

    localparam int WIDTH = 1 << LOG_WIDTH;

    always_comb begin
        mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (tailIdx >= headIdx) begin
                mask[i] = (i >= int'(headIdx)) && (i < int'(tailIdx));
            end else begin
                mask[i] = !((i >= int'(tailIdx)) && (i < int'(headIdx)));
            end
        end
    end

endmodule

// File: rtl/prefetch_ring_tracker.sv
// In-order ring of outstanding prefetch addresses: allocate at tail, complete by index,
// retire from head, and answer registered address lookups against the live region.
module prefetch_ring_tracker
    import prefetch_ring_pkg::*;
#(
    parameter int LOG_DEPTH  = 3,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  flush,
    input  logic                  pushValid,
    input  logic [ADDR_WIDTH-1:0] pushAddr,
    output logic                  pushReady,
    output logic [LOG_DEPTH-1:0]  pushIdx,
    input  logic                  cmplValid,
    input  logic [LOG_DEPTH-1:0]  cmplIdx,
    output logic                  popValid,
    input  logic                  popReady,
    output logic [ADDR_WIDTH-1:0] popAddr,
    input  logic                  lookupValid,
    input  logic [ADDR_WIDTH-1:0] lookupAddr,
    output logic                  hitValid,
    output logic                  hit,
    output logic [LOG_DEPTH-1:0]  hitIdx,
    output logic                  hitDone,
    output logic [LOG_DEPTH:0]    count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << LOG_DEPTH;

    logic [LOG_DEPTH-1:0]  head_q, head_d, tail_q, tail_d;
    logic [LOG_DEPTH:0]    count_q, count_d;
    logic [DEPTH-1:0]      done_q, done_d;
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];

    logic [DEPTH-1:0]      raw_mask, valid_mask, match;
    logic                  push_fire, pop_fire, hit_d;
    logic [LOG_DEPTH-1:0]  hit_idx_d;

    logic                  hit_valid_q, hit_q, hit_done_q;
    logic [LOG_DEPTH-1:0]  hit_idx_q;

    vectorMask #(.LOG_WIDTH(LOG_DEPTH)) u_mask (
        .headIdx (head_q),
        .tailIdx (tail_q),
        .mask    (raw_mask)
    );

    assign empty     = (count_q == '0);
    assign full      = (count_q == (LOG_DEPTH+1)'(DEPTH));
    assign pushReady = !full;
    assign pushIdx   = tail_q;
    assign popValid  = !empty && done_q[head_q];
    assign popAddr   = addr_q[head_q];
    assign count     = count_q;
    assign push_fire = pushValid && pushReady;
    assign pop_fire  = popValid && popReady;

    assign hitValid  = hit_valid_q;
    assign hit       = hit_q;
    assign hitIdx    = hit_idx_q;
    assign hitDone   = hit_done_q;

    // head == tail is ambiguous in the raw mask; occupancy resolves it
    always_comb begin
        valid_mask = raw_mask;
        if (empty) begin
            valid_mask = '0;
        end else if (full) begin
            valid_mask = '1;
        end
    end

    always_comb begin
        match     = '0;
        hit_idx_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid_mask[i] && (addr_q[i] == lookupAddr);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_idx_d = LOG_DEPTH'(i);
            end
        end
        hit_d = |match;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        done_d  = done_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            done_d  = '0;
        end else begin
            if (cmplValid && valid_mask[cmplIdx]) begin
                done_d[cmplIdx] = 1'b1;
            end
            if (push_fire) begin
                done_d[tail_q] = 1'b0;
                tail_d         = LOG_DEPTH'(next_idx(32'(tail_q), DEPTH));
            end
            if (pop_fire) begin
                head_d = LOG_DEPTH'(next_idx(32'(head_q), DEPTH));
            end
            case ({push_fire, pop_fire})
                2'b10:   count_d = count_q + (LOG_DEPTH+1)'(1);
                2'b01:   count_d = count_q - (LOG_DEPTH+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            done_q      <= '0;
            hit_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            hit_idx_q   <= '0;
            hit_done_q  <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            done_q      <= done_d;
            hit_valid_q <= lookupValid;
            if (flush) begin
                hit_q      <= 1'b0;
                hit_idx_q  <= '0;
                hit_done_q <= 1'b0;
            end else begin
                hit_q      <= hit_d;
                hit_idx_q  <= hit_idx_d;
                hit_done_q <= done_q[hit_idx_d];
            end
        end
    end

    // Address payload carries no reset; only slots inside the live region are ever observed
    always_ff @(posedge clk) begin
        if (push_fire && !flush) begin
            addr_q[tail_q] <= pushAddr;
        end
    end

endmodule

// File: tb/tb_prefetch_ring_tracker.sv
// Randomized and directed bench for prefetch_ring_tracker against an occupancy-based ring model.
module tb_prefetch_ring_tracker;

    localparam int LD = 2;
    localparam int D  = 4;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        flush = 1'b0;
    logic        pushValid = 1'b0;
    logic [63:0] pushAddr = '0;
    logic        pushReady;
    logic [1:0]  pushIdx;
    logic        cmplValid = 1'b0;
    logic [1:0]  cmplIdx = '0;
    logic        popValid;
    logic        popReady = 1'b0;
    logic [63:0] popAddr;
    logic        lookupValid = 1'b0;
    logic [63:0] lookupAddr = '0;
    logic        hitValid, hit, hitDone;
    logic [1:0]  hitIdx;
    logic [2:0]  count;
    logic        full, empty;

    int n_cmp = 0;
    int n_err = 0;

    // Model: slot contents plus head and occupancy; the live region is head..head+cnt-1 mod D
    logic [63:0] m_addr [D];
    bit          m_done [D];
    int          m_head, m_cnt;
    bit          m_hv, m_hit, m_hdone;
    int          m_hidx;
    logic [63:0] pool [6];

    prefetch_ring_tracker #(.LOG_DEPTH(LD), .ADDR_WIDTH(64)) dut (
        .clk(clk), .resetN(resetN), .flush(flush),
        .pushValid(pushValid), .pushAddr(pushAddr), .pushReady(pushReady), .pushIdx(pushIdx),
        .cmplValid(cmplValid), .cmplIdx(cmplIdx),
        .popValid(popValid), .popReady(popReady), .popAddr(popAddr),
        .lookupValid(lookupValid), .lookupAddr(lookupAddr),
        .hitValid(hitValid), .hit(hit), .hitIdx(hitIdx), .hitDone(hitDone),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_reg(input int i);
        return ((i - m_head + D) % D) < m_cnt;
    endfunction

    task automatic model_reset();
        m_head = 0;
        m_cnt  = 0;
        for (int i = 0; i < D; i++) m_done[i] = 1'b0;
        m_hv = 0; m_hit = 0; m_hidx = 0; m_hdone = 0;
    endtask

    task automatic check_all();
        bit exp_pop;
        exp_pop = (m_cnt > 0) && m_done[m_head];
        chk("count", 64'(count), 64'(m_cnt));
        chk("empty", 64'(empty), 64'(m_cnt == 0));
        chk("full", 64'(full), 64'(m_cnt == D));
        chk("pushReady", 64'(pushReady), 64'(m_cnt < D));
        chk("pushIdx", 64'(pushIdx), 64'((m_head + m_cnt) % D));
        chk("popValid", 64'(popValid), 64'(exp_pop));
        if (exp_pop) chk("popAddr", popAddr, m_addr[m_head]);
        chk("hitValid", 64'(hitValid), 64'(m_hv));
        if (m_hv) begin
            chk("hit", 64'(hit), 64'(m_hit));
            chk("hitIdx", 64'(hitIdx), 64'(m_hidx));
            chk("hitDone", 64'(hitDone), 64'(m_hdone));
        end
    endtask

    // One clock: derive the model's next state from pre-edge state and inputs, clock, then compare
    task automatic step();
        bit nh, nd, push_ok, pop_ok, cmpl_ok;
        int nidx, tail;
        tail = (m_head + m_cnt) % D;
        nh = 0; nidx = 0;
        for (int i = 0; i < D; i++) begin
            if (!nh && in_reg(i) && m_addr[i] == lookupAddr) begin
                nh = 1; nidx = i;
            end
        end
        nd      = m_done[nidx];
        push_ok = pushValid && (m_cnt < D);
        pop_ok  = popReady && (m_cnt > 0) && m_done[m_head];
        cmpl_ok = cmplValid && in_reg(int'(cmplIdx));
        @(posedge clk);
        #1;
        m_hv = lookupValid;
        if (flush) begin
            model_reset();
            m_hv = lookupValid;
        end else begin
            m_hit = nh; m_hidx = nidx; m_hdone = nd;
            if (cmpl_ok) m_done[cmplIdx] = 1'b1;
            if (push_ok) begin
                m_addr[tail] = pushAddr;
                m_done[tail] = 1'b0;
            end
            if (pop_ok) m_head = (m_head + 1) % D;
            m_cnt = m_cnt + int'(push_ok) - int'(pop_ok);
        end
        check_all();
        flush = 0; pushValid = 0; popReady = 0; cmplValid = 0; lookupValid = 0;
    endtask

    task automatic push(input logic [63:0] a);
        pushValid = 1; pushAddr = a;
    endtask

    task automatic lookup(input logic [63:0] a);
        lookupValid = 1; lookupAddr = a;
    endtask

    task automatic cmpl(input int i);
        cmplValid = 1; cmplIdx = 2'(i);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_empty"}, 64'(empty), 64'd1);
        chk({tag, "_full"}, 64'(full), 64'd0);
        chk({tag, "_pushReady"}, 64'(pushReady), 64'd1);
        chk({tag, "_popValid"}, 64'(popValid), 64'd0);
        chk({tag, "_pushIdx"}, 64'(pushIdx), 64'd0);
        chk({tag, "_count"}, 64'(count), 64'd0);
        chk({tag, "_hitValid"}, 64'(hitValid), 64'd0);
        chk({tag, "_hit"}, 64'(hit), 64'd0);
    endtask

    initial begin
        for (int k = 0; k < 6; k++) pool[k] = 64'h1000 + 64'(k) * 64'h40;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        resetN = 1;

        // Fill three entries and look one up
        chk("lit_pushIdx0", 64'(pushIdx), 64'd0);
        push(64'h100); step();
        chk("lit_pushIdx1", 64'(pushIdx), 64'd1);
        push(64'h140); step();
        chk("lit_pushIdx2", 64'(pushIdx), 64'd2);
        push(64'h180); step();
        chk("lit_count3", 64'(count), 64'd3);
        chk("lit_popValid0", 64'(popValid), 64'd0);
        chk("pin_mcnt", 64'(m_cnt), 64'd3);
        chk("pin_mhead", 64'(m_head), 64'd0);
        lookup(64'h140); step();
        chk("lit_hit", 64'(hit), 64'd1);
        chk("lit_hitIdx", 64'(hitIdx), 64'd1);
        chk("lit_hitDone", 64'(hitDone), 64'd0);
        chk("pin_mhidx", 64'(m_hidx), 64'd1);

        // Full ring rejects an extra push
        push(64'h1C0); step();
        chk("lit_full", 64'(full), 64'd1);
        chk("lit_pushReady0", 64'(pushReady), 64'd0);
        push(64'h1C0); step();
        chk("lit_count4", 64'(count), 64'd4);
        cmpl(0); step();
        chk("lit_popValid1", 64'(popValid), 64'd1);
        chk("lit_popAddr", popAddr, 64'h100);
        popReady = 1; step();
        chk("lit_full_clr", 64'(full), 64'd0);
        chk("lit_count3b", 64'(count), 64'd3);

        // Move to head=3, tail=1 so the live region straddles the wrap
        cmpl(1); step();
        cmpl(2); popReady = 1; step();
        popReady = 1; step();
        push(64'h200); step();
        chk("lit_pushIdx_wrap", 64'(pushIdx), 64'd1);
        lookup(64'h180); step();
        chk("lit_stale_miss", 64'(hit), 64'd0);
        lookup(64'h200); step();
        chk("lit_wrap_hit", 64'(hit), 64'd1);
        chk("lit_wrap_idx", 64'(hitIdx), 64'd0);

        // Simultaneous push and pop at count 2
        cmpl(3); step();
        push(64'h240); popReady = 1; step();
        chk("lit_pp_count", 64'(count), 64'd2);
        chk("lit_pp_pushIdx", 64'(pushIdx), 64'd2);

        // Completion outside region (head=0, tail=2) is dropped
        cmpl(3); step();
        push(64'h280); step();
        push(64'h2C0); step();
        lookup(64'h2C0); step();
        chk("lit_oob_idx", 64'(hitIdx), 64'd3);
        chk("lit_oob_done", 64'(hitDone), 64'd0);

        // Flush with three entries, concurrent push and lookup
        cmpl(0); step();
        popReady = 1; step();
        chk("lit_pre_flush", 64'(count), 64'd3);
        flush = 1; push(64'h300); lookup(64'h280); step();
        chk("lit_flush_count", 64'(count), 64'd0);
        chk("lit_flush_empty", 64'(empty), 64'd1);
        chk("lit_flush_hv", 64'(hitValid), 64'd1);
        chk("lit_flush_hit", 64'(hit), 64'd0);

        // Asynchronous reset in the middle of activity
        push(64'h340); step();
        push(64'h380); lookup(64'h340); step();
        #2 resetN = 0;
        #1 check_reset_outputs("arst");
        model_reset();
        @(negedge clk);
        resetN = 1;

        // Randomized traffic over a small address pool so hits and duplicates occur
        for (int c = 0; c < 3000; c++) begin
            pushValid   = $urandom_range(0, 1) == 1;
            pushAddr    = pool[$urandom_range(0, 5)];
            popReady    = $urandom_range(0, 1) == 1;
            cmplValid   = $urandom_range(0, 3) != 0;
            cmplIdx     = 2'($urandom_range(0, 3));
            lookupValid = $urandom_range(0, 1) == 1;
            lookupAddr  = pool[$urandom_range(0, 5)];
            flush       = $urandom_range(0, 49) == 0;
            step();
            if (c == 1500) begin
                #2 resetN = 0;
                #1 check_reset_outputs("arst2");
                model_reset();
                @(negedge clk);
                resetN = 1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
